// File: rtl/mux_4x1_tdm.sv
// mux_4x1_tdm: four-channel round-robin time-division multiplexer.
// Ports: clk, rst (sync, active-high); i0..i3/v0..v3/r0..r3 channel
//   handshakes; Y, s0 (select MSB), s1 (select LSB), Y_valid registered out.
module mux_4x1_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [WIDTH-1:0] Y,
    output logic             s0,
    output logic             s1,
    output logic             Y_valid
);

    logic [WIDTH-1:0] in_w [4];
    logic [3:0]       v_w;

    logic [WIDTH-1:0] h_q [4];
    logic [WIDTH-1:0] h_d [4];
    logic [3:0]       f_q, f_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             yv_q, yv_d;

    logic             grant;
    logic [1:0]       win;
    logic [1:0]       cand;
    logic [3:0]       cap;

    assign in_w[0] = i0;
    assign in_w[1] = i1;
    assign in_w[2] = i2;
    assign in_w[3] = i3;
    assign v_w     = {v3, v2, v1, v0};

    // A channel is ready exactly when its holding register is empty.
    assign r0 = ~f_q[0];
    assign r1 = ~f_q[1];
    assign r2 = ~f_q[2];
    assign r3 = ~f_q[3];

    assign Y       = y_q;
    assign s0      = sel_q[1];
    assign s1      = sel_q[0];
    assign Y_valid = yv_q;

    // Round-robin search starting just after the last served channel;
    // offset 4 wraps back to ptr itself so a lone full channel still wins.
    always_comb begin
        grant = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int j = 1; j <= 4; j++) begin
            cand = ptr_q + 2'(j);
            if (!grant && f_q[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        y_d   = y_q;
        sel_d = sel_q;
        ptr_d = ptr_q;
        yv_d  = grant;
        cap   = v_w & ~f_q;
        f_d   = f_q;
        for (int k = 0; k < 4; k++) begin
            h_d[k] = h_q[k];
        end
        if (grant) begin
            y_d   = h_q[win];
            sel_d = win;
            ptr_d = win;
        end
        // Capture only into empty slots, so it never collides with the
        // grant-clear of the same channel at one edge.
        for (int k = 0; k < 4; k++) begin
            if (cap[k]) begin
                f_d[k] = 1'b1;
                h_d[k] = in_w[k];
            end else if (grant && win == 2'(k)) begin
                f_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q   <= '0;
            ptr_q <= 2'd3;
            sel_q <= '0;
            y_q   <= '0;
            yv_q  <= 1'b0;
        end else begin
            f_q   <= f_d;
            ptr_q <= ptr_d;
            sel_q <= sel_d;
            y_q   <= y_d;
            yv_q  <= yv_d;
        end
    end

    // Held data needs no reset: it is only read while its full flag is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            h_q[k] <= h_d[k];
        end
    end

endmodule

// File: tb/tb_mux_4x1_tdm.sv
// tb_mux_4x1_tdm: randomized and directed bench for mux_4x1_tdm
// checked against a transaction-level round-robin reference model.
module tb_mux_4x1_tdm;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
    logic         v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic         r0, r1, r2, r3;
    logic [W-1:0] Y;
    logic         s0, s1, Y_valid;

    int n_cmp = 0;
    int n_err = 0;
    string phase = "init";

    // Reference model state: per-channel held word, last served index,
    // and the expected registered outputs.
    bit mf [4];
    int mh [4];
    int mlast;
    int ey, esel;
    bit eyv;

    mux_4x1_tdm #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .Y(Y), .s0(s0), .s1(s1), .Y_valid(Y_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s [%s] t=%0t got=%0d want=%0d",
                     tag, phase, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mf[k] = 0;
        mlast = 3;
        ey    = 0;
        esel  = 0;
        eyv   = 0;
    endtask

    task automatic model_edge(input bit r, input bit [3:0] v,
                              input int d [4]);
        bit cap [4];
        int w;
        if (r) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 4; k++) cap[k] = v[k] && !mf[k];
        w = -1;
        for (int d2 = 1; d2 <= 4; d2++) begin
            if (w < 0 && mf[(mlast + d2) % 4]) w = (mlast + d2) % 4;
        end
        if (w >= 0) begin
            ey    = mh[w];
            esel  = w;
            eyv   = 1;
            mf[w] = 0;
            mlast = w;
        end else begin
            eyv = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (cap[k]) begin
                mf[k] = 1;
                mh[k] = d[k];
            end
        end
    endtask

    // One cycle: check outputs settled from the last edge, apply inputs,
    // then advance the model at the next rising edge.
    task automatic step(input bit r, input bit [3:0] v,
                        input int a, input int b, input int c, input int e);
        int d [4];
        int rexp;
        @(negedge clk);
        rexp = 0;
        for (int k = 0; k < 4; k++) rexp |= (mf[k] ? 0 : 1) << k;
        chk("Y", int'(Y), ey);
        chk("sel", int'({s0, s1}), esel);
        chk("Y_valid", int'(Y_valid), int'(eyv));
        chk("ready", int'({r3, r2, r1, r0}), rexp);
        d[0] = a; d[1] = b; d[2] = c; d[3] = e;
        rst = r;
        {v3, v2, v1, v0} = v;
        i0 = W'(a); i1 = W'(b); i2 = W'(c); i3 = W'(e);
        @(posedge clk);
        model_edge(r, v, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 4'b0000, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();

        phase = "reset_idle";
        step(1, 4'b0000, 0, 0, 0, 0);
        step(1, 4'b0000, 0, 0, 0, 0);
        idle(5);

        phase = "single";
        step(0, 4'b0100, 0, 0, 1, 0);
        idle(3);

        phase = "all_four";
        step(0, 4'b1111, 1, 0, 1, 1);
        idle(6);

        phase = "fairness";
        for (int k = 0; k < 8; k++)
            step(0, 4'b1001, $urandom_range(15), 0, 0, $urandom_range(15));
        idle(4);

        phase = "backpressure";
        step(0, 4'b0010, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 4'b0010, 0, 1, 0, 0);
        idle(4);

        phase = "reset_mid";
        step(0, 4'b0111, 5, 6, 7, 0);
        step(0, 4'b0000, 0, 0, 0, 0);
        step(1, 4'b0000, 0, 0, 0, 0);
        idle(4);
        step(0, 4'b0010, 0, 9, 0, 0);
        idle(3);

        phase = "random";
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(60) == 0), 4'($urandom),
                 $urandom_range(15), $urandom_range(15),
                 $urandom_range(15), $urandom_range(15));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
